// File: rtl/warp_hazard_scoreboard.sv
// Per-warp hazard tracker feeding the warp scheduler's blocked vector.
// Tracks ALU latency, outstanding long-latency ops and wait-for-long barriers.
module warp_hazard_scoreboard #(
  parameter int WARP_CNT = 64,
  parameter int ALU_LAT  = 4,
  parameter int MAX_PEND = 7,
  parameter int IDX_W    = $clog2(WARP_CNT),
  parameter int CNT_W    = $clog2(MAX_PEND + 1),
  parameter int TMR_W    = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WARP_CNT-1:0] issue_mask,
  input  logic [WARP_CNT-1:0] issue_long,
  input  logic [WARP_CNT-1:0] issue_wait,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_idx,
  output logic [WARP_CNT-1:0] scoreboard,
  output logic                pend_any,
  output logic                err_ovf,
  output logic                err_unf
);

  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MAX_PEND);
  localparam logic [IDX_W:0]   LP_WCNT = (IDX_W + 1)'(WARP_CNT);

  logic                w_idx_ok;
  logic [WARP_CNT-1:0] w_ovf;
  logic [WARP_CNT-1:0] w_unf;
  logic [WARP_CNT-1:0] w_pend;
  logic [WARP_CNT-1:0] w_blk;
  logic                r_err_ovf;
  logic                r_err_unf;

  assign w_idx_ok = {1'b0, wb_idx} < LP_WCNT;

  for (genvar g = 0; g < WARP_CNT; g++) begin : g_warp
    logic [CNT_W-1:0] r_lcnt;
    logic [CNT_W-1:0] w_lcnt_nxt;
    logic             r_wait;
    logic             w_inc;
    logic             w_dec;
    logic             w_ovf_l;
    logic             w_unf_l;
    logic             w_tmr_on;

    assign w_inc = issue_mask[g] & issue_long[g];
    assign w_dec = wb_valid & w_idx_ok & (wb_idx == IDX_W'(g));

    // Simultaneous inc and dec cancel, so neither bound can trip.
    always_comb begin
      w_lcnt_nxt = r_lcnt;
      w_ovf_l    = 1'b0;
      w_unf_l    = 1'b0;
      if (w_inc && !w_dec) begin
        if (r_lcnt == LP_MAX) w_ovf_l = 1'b1;
        else w_lcnt_nxt = r_lcnt + CNT_W'(1);
      end else if (w_dec && !w_inc) begin
        if (r_lcnt == '0) w_unf_l = 1'b1;
        else w_lcnt_nxt = r_lcnt - CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_lcnt <= '0;
        r_wait <= 1'b0;
      end else begin
        r_lcnt <= w_lcnt_nxt;
        r_wait <= (r_wait | (issue_mask[g] & issue_wait[g]))
                  & (w_lcnt_nxt != '0);
      end
    end

    if (ALU_LAT > 0) begin : g_tmr
      localparam logic [TMR_W-1:0] LP_LAT = TMR_W'(ALU_LAT);
      logic [TMR_W-1:0] r_tcnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tcnt <= '0;
        else if (issue_mask[g]) r_tcnt <= LP_LAT;
        else if (r_tcnt != '0) r_tcnt <= r_tcnt - TMR_W'(1);
      end

      assign w_tmr_on = r_tcnt != '0;
    end else begin : g_notmr
      assign w_tmr_on = 1'b0;
    end

    assign w_ovf[g]  = w_ovf_l;
    assign w_unf[g]  = w_unf_l;
    assign w_pend[g] = r_lcnt != '0;
    assign w_blk[g]  = w_tmr_on | (r_wait & w_pend[g])
                       | (r_lcnt == LP_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_err_ovf <= r_err_ovf | (|w_ovf);
      r_err_unf <= r_err_unf | (|w_unf) | (wb_valid & ~w_idx_ok);
    end
  end

  // Decoded purely from registers: issue_mask is fed by this output.
  assign scoreboard = w_blk;
  assign pend_any   = |w_pend;
  assign err_ovf    = r_err_ovf;
  assign err_unf    = r_err_unf;

endmodule

// File: tb/tb_warp_hazard_scoreboard.sv
// Directed bench for warp_hazard_scoreboard: vector table plus
// hand-written multi-cycle sequences.
module tb_warp_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic [63:0] issue_mask;
  logic [63:0] issue_long;
  logic [63:0] issue_wait;
  logic        wb_valid;
  logic [5:0]  wb_idx;
  logic [63:0] scoreboard;
  logic        pend_any;
  logic        err_ovf;
  logic        err_unf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] m;
    logic [63:0] l;
    logic [63:0] w;
    logic        wv;
    logic [5:0]  idx;
    logic [63:0] e_sb;
    logic        e_pend;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t tv[$];

  warp_hazard_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .issue_mask (issue_mask),
    .issue_long (issue_long),
    .issue_wait (issue_wait),
    .wb_valid   (wb_valid),
    .wb_idx     (wb_idx),
    .scoreboard (scoreboard),
    .pend_any   (pend_any),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [63:0] m, logic [63:0] l,
                              logic [63:0] w, logic wv, logic [5:0] idx,
                              logic [63:0] sb, logic p);
    vec_t v;
    v.m = m; v.l = l; v.w = w; v.wv = wv; v.idx = idx;
    v.e_sb = sb; v.e_pend = p; v.e_ovf = 1'b0; v.e_unf = 1'b0;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(logic [63:0] m, logic [63:0] l, logic [63:0] w,
                      logic wv, logic [5:0] idx);
    issue_mask = m; issue_long = l; issue_wait = w;
    wb_valid = wv; wb_idx = idx;
    @(posedge clk);
    #1;
    issue_mask = '0; issue_long = '0; issue_wait = '0;
    wb_valid = 1'b0; wb_idx = '0;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    issue_mask = '0; issue_long = '0; issue_wait = '0;
    wb_valid = 1'b0; wb_idx = '0;

    // reset state
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    // ALU issue warp 5, re-issue two cycles later
    tv.push_back(mk(64'h20, 0, 0, 0, 0, 64'h20, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'h20, 0));
    tv.push_back(mk(64'h20, 0, 0, 0, 0, 64'h20, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'h20, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'h20, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'h20, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'h0, 0));
    // long op to warp 1, no wait: only ALU-blocked
    tv.push_back(mk(64'h2, 64'h2, 0, 0, 0, 64'h2, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'h2, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'h2, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'h2, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'h0, 1));
    // multi-hot issue with same-cycle wb to warp 1; wait on idle warps 2,3
    tv.push_back(mk(64'hF, 64'h3, 64'hC, 1, 6'd1, 64'hF, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'hF, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'hF, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'hF, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 64'h0, 1));
    // drain warp 0 then warp 1 (each exactly one pending)
    tv.push_back(mk(0, 0, 0, 1, 6'd0, 64'h0, 1));
    tv.push_back(mk(0, 0, 0, 1, 6'd1, 64'h0, 0));

    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].m, tv[i].l, tv[i].w, tv[i].wv, tv[i].idx);
      chk($sformatf("vec%0d sb", i), scoreboard, tv[i].e_sb);
      chk($sformatf("vec%0d pend", i), 64'(pend_any), 64'(tv[i].e_pend));
      chk($sformatf("vec%0d ovf", i), 64'(err_ovf), 64'(tv[i].e_ovf));
      chk($sformatf("vec%0d unf", i), 64'(err_unf), 64'(tv[i].e_unf));
    end

    // long + wait on warp 3, second long two cycles later
    step(64'h8, 64'h8, 64'h8, 1'b0, '0);
    chk("lw first", scoreboard, 64'h8);
    chk("lw pend", 64'(pend_any), 64'd1);
    idle(1);
    step(64'h8, 64'h8, 64'h0, 1'b0, '0);
    idle(8);
    chk("lw held", scoreboard, 64'h8);
    step('0, '0, '0, 1'b1, 6'd3);
    chk("lw wb1", scoreboard, 64'h8);
    idle(5);
    chk("lw wb1 late", scoreboard, 64'h8);
    step('0, '0, '0, 1'b1, 6'd3);
    chk("lw release", scoreboard, 64'h0);
    chk("lw pend clr", 64'(pend_any), 64'd0);

    // saturation on warp 0
    for (int k = 0; k < 6; k++) step(64'h1, 64'h1, '0, 1'b0, '0);
    idle(5);
    chk("sat six", scoreboard, 64'h0);
    chk("sat six pend", 64'(pend_any), 64'd1);
    step(64'h1, 64'h1, '0, 1'b0, '0);
    idle(5);
    chk("sat seven", scoreboard, 64'h1);
    step(64'h1, 64'h1, '0, 1'b1, 6'd0);
    chk("sat same ovf", 64'(err_ovf), 64'd0);
    idle(5);
    chk("sat same sb", scoreboard, 64'h1);
    step(64'h1, 64'h1, '0, 1'b0, '0);
    chk("sat ovf", 64'(err_ovf), 64'd1);
    idle(5);
    chk("sat hold", scoreboard, 64'h1);
    step('0, '0, '0, 1'b1, 6'd0);
    chk("sat unblk", scoreboard, 64'h0);
    chk("sat unblk pend", 64'(pend_any), 64'd1);
    for (int k = 0; k < 6; k++) step('0, '0, '0, 1'b1, 6'd0);
    chk("sat drain pend", 64'(pend_any), 64'd0);
    chk("sat drain unf", 64'(err_unf), 64'd0);

    // underflow on warp 9, sticky through later traffic
    step('0, '0, '0, 1'b1, 6'd9);
    chk("unf set", 64'(err_unf), 64'd1);
    step(64'h200, 64'h200, '0, 1'b0, '0);
    step('0, '0, '0, 1'b1, 6'd9);
    chk("unf sticky", 64'(err_unf), 64'd1);
    chk("unf pend", 64'(pend_any), 64'd0);
    chk("ovf sticky", 64'(err_ovf), 64'd1);

    // asynchronous reset mid-operation
    step(64'h14, 64'h14, 64'h14, 1'b0, '0);
    idle(5);
    chk("rst pre sb", scoreboard, 64'h14);
    #2 rst = 1'b1;
    #1;
    chk("rst sb", scoreboard, 64'h0);
    chk("rst pend", 64'(pend_any), 64'd0);
    chk("rst ovf", 64'(err_ovf), 64'd0);
    chk("rst unf", 64'(err_unf), 64'd0);
    #1 rst = 1'b0;
    step('0, '0, '0, 1'b1, 6'd2);
    chk("rst late wb unf", 64'(err_unf), 64'd1);
    chk("rst late wb sb", scoreboard, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/warp_hazard_scoreboard.md
# warp_hazard_scoreboard

Per-warp hazard tracker that produces the `scoreboard` blocked vector consumed by the warp scheduler. It watches the warps the scheduler actually issues and the writebacks returned by long-latency units (memory/SFU). It then holds each warp blocked until its dependencies clear. It sits between the scheduler's `sel_mask` output and its `scoreboard` input, closing the issue loop.

## Interface
- WARP_CNT, 64, number of resident warps
- ALU_LAT, 4, cycles a warp stays blocked after any issue (fixed-latency pipe); 0 disables
- MAX_PEND, 7, max outstanding long-latency ops per warp
- IDX_W, $clog2(WARP_CNT), warp index width
- CNT_W, $clog2(MAX_PEND+1), pending-counter width
- TMR_W, $clog2(ALU_LAT+1) (min 1), ALU timer width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_mask  in  WARP_CNT  warps issued this cycle (scheduler sel_mask, multi-hot)
- issue_long  in  WARP_CNT  issued op is long-latency; bits ignored where issue_mask=0
- issue_wait  in  WARP_CNT  issued op's successor must wait for all long ops of that warp; ignored where issue_mask=0
- wb_valid  in  1  one long-latency completion this cycle
- wb_idx  in  IDX_W  warp of completion
- scoreboard  out  WARP_CNT  1 = warp blocked
- pend_any  out  1  any warp has lcnt != 0
- err_ovf  out  1  sticky: long issue to a warp at MAX_PEND
- err_unf  out  1  sticky: writeback to a warp with lcnt == 0

## Operation
- Per-warp state: tcnt[TMR_W], lcnt[CNT_W], wait[1]. All reset to 0; err_ovf/err_unf reset to 0.
- tcnt: loads ALU_LAT when issue_mask[w]=1. Otherwise it decrements when nonzero. A reload while nonzero restarts the count.
- lcnt: +1 when issue_mask[w]&issue_long[w]; −1 when wb_valid && wb_idx==w.
  - Both in the same cycle: net unchanged; no error, even at MAX_PEND or 0.
  - Increment at MAX_PEND with no matching wb: counter holds, err_ovf←1.
  - Decrement at 0 with no matching increment: counter holds, err_unf←1.
  - wb_idx ≥ WARP_CNT: ignored, err_unf←1.
- wait: wait_next = (wait | (issue_mask[w]&issue_wait[w])) & (lcnt_next != 0). A wait issue with no pending long ops therefore never blocks.
- scoreboard[w] = (tcnt!=0) | (wait & lcnt!=0) | (lcnt==MAX_PEND). It is decoded only from registered state; there is no combinational path from any input to scoreboard. This is required because the scheduler's output feeds issue_mask, so an input path would form a loop.
- pend_any = OR over lcnt!=0, from registered state.
- Issue to an already-blocked warp is not checked; the state updates as specified above.
- Error flags clear only on rst.

## Timing
- Issue in cycle t, ALU_LAT=L>0: scoreboard[w]=1 in cycles t+1 … t+L, and 0 at t+L+1 unless the long/wait terms hold.
- ALU_LAT=0: the tcnt term is constant 0.
- Long issue with wait at t: blocked from t+1. The final matching wb at cycle u → lcnt=0 and wait=0 at u+1, so the warp is unblocked at u+1 (subject to tcnt).
- Saturation: the issue that brings lcnt to MAX_PEND at t → blocked from t+1. A wb at u → unblocked at u+1.
- Error flags assert the cycle after the offending input.
- rst asserted mid-operation: all counters, wait bits, scoreboard, pend_any and error flags go to 0 immediately (asynchronous). In-flight writebacks arriving after reset release count as underflow.

## Test plan
- Single ALU issue: ALU_LAT=4, issue_mask bit 5 at cycle 10 → scoreboard[5]=1 in cycles 11–14 and 0 at 15. Re-issue at 12 → high through 16.
- Long + wait: issue warp 3 long+wait at t, plus a second long at t+2. wb(3) at t+20 → still blocked. wb(3) at t+30 → scoreboard[3]=0 at t+31 and pend_any=0.
- Saturation: MAX_PEND=7, seven long issues to warp 0 → blocked after the 7th. 8th long issue → err_ovf=1 and lcnt stays 7. Same-cycle issue+wb at 7 → no error.
- Simultaneous: multi-hot issue_mask=0x…0F with issue_long=0x3, plus wb to warp 1 (lcnt 1) in the same cycle → warp 1 lcnt unchanged (1), warp 0 lcnt=1, warps 2–3 only ALU-blocked.
- Underflow: wb to warp 9 with lcnt=0 → err_unf=1 next cycle, and the flag stays set through later traffic.
- Reset mid-op: several warps blocked with pending ops; pulse rst for a partial cycle → scoreboard=0 and pend_any=0 immediately. A later wb → err_unf=1.
